// File: rtl/mpu_fetch.sv
// MPU instruction fetch/decode front end: reads the 6-byte window at pc, decodes
// one variable-length instruction and hands it to execute over valid/ready.
module mpu_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned MEM_BYTES = 128,
  parameter logic [3:0]  OP_LOAD   = 4'h1,
  parameter logic [3:0]  OP_MASK   = 4'h2,
  parameter logic [3:0]  OP_INT    = 4'h3,
  parameter logic [3:0]  OP_JMP    = 4'h4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  output logic [15:0] r_addr,
  input  logic [47:0] r_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [3:0]  instr_op,
  output logic [1:0]  instr_size,
  output logic [2:0]  instr_len,
  output logic [39:0] instr_operands,
  output logic [15:0] instr_pc,
  input  logic        jmp_valid,
  input  logic [15:0] jmp_addr,
  output logic        halted,
  output logic [1:0]  error
);

  localparam int unsigned PC_W    = 16;
  localparam int unsigned OPS_W   = 40;
  localparam int unsigned OPS_NUM = 5;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OP    = 2'b01;
  localparam logic [1:0] ERR_SIZE  = 2'b10;
  localparam logic [1:0] ERR_RANGE = 2'b11;

  localparam logic [PC_W:0] MEM_END = (PC_W+1)'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_JMP,
    S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]  pc, pc_d;
  logic             instr_valid_d;
  logic [3:0]       instr_op_d;
  logic [1:0]       instr_size_d;
  logic [2:0]       instr_len_d;
  logic [OPS_W-1:0] instr_operands_d;
  logic [PC_W-1:0]  instr_pc_d;
  logic             halted_d;
  logic [1:0]       error_d;

  logic [3:0]       dec_op;
  logic [1:0]       dec_size;
  logic [2:0]       dec_len;
  logic [1:0]       dec_err;
  logic [PC_W:0]    dec_end;
  logic [OPS_W-1:0] dec_ops;

  // byte0[3:2] carry no meaning for the fetch stage
  logic unused_byte0_bits;
  assign unused_byte0_bits = ^r_data[3:2];

  assign r_addr = pc;

  // Length/legality decode of the window at pc; opcode/size errors beat range errors
  always_comb begin
    dec_op   = r_data[7:4];
    dec_size = r_data[1:0];
    dec_len  = 3'd0;
    dec_err  = ERR_NONE;
    dec_ops  = '0;

    if (dec_op == OP_LOAD) begin
      case (dec_size)
        2'b00:   dec_len = 3'd3;
        2'b01:   dec_len = 3'd4;
        2'b10:   dec_len = 3'd6;
        default: dec_err = ERR_SIZE;
      endcase
    end else if (dec_op == OP_MASK) begin
      dec_len = 3'd5;
    end else if (dec_op == OP_INT || dec_op == OP_JMP) begin
      dec_len = 3'd2;
    end else begin
      dec_err = ERR_OP;
    end

    dec_end = {1'b0, pc} + (PC_W+1)'(dec_len);
    if (dec_err == ERR_NONE && ({1'b0, pc} >= MEM_END || dec_end > MEM_END)) begin
      dec_err = ERR_RANGE;
    end

    // Operand byte k survives only if it lies inside the instruction
    for (int k = 1; k <= OPS_NUM; k++) begin
      if (3'(k) < dec_len) begin
        dec_ops[8*(k-1) +: 8] = r_data[8*k +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = (dec_err == ERR_NONE) ? S_ISSUE : S_HALT;
      end
      S_ISSUE: begin
        if (instr_valid && instr_ready) begin
          if (instr_op == OP_JMP) state_nxt = S_WAIT_JMP;
          else                    state_nxt = en ? S_FETCH : S_IDLE;
        end
      end
      S_WAIT_JMP: begin
        if (jmp_valid) state_nxt = en ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; everything holds unless the state says otherwise
  always_comb begin
    pc_d             = pc;
    instr_valid_d    = instr_valid;
    instr_op_d       = instr_op;
    instr_size_d     = instr_size;
    instr_len_d      = instr_len;
    instr_operands_d = instr_operands;
    instr_pc_d       = instr_pc;
    halted_d         = halted;
    error_d          = error;

    case (state)
      S_FETCH: begin
        if (dec_err == ERR_NONE) begin
          instr_valid_d    = 1'b1;
          instr_op_d       = dec_op;
          instr_size_d     = dec_size;
          instr_len_d      = dec_len;
          instr_operands_d = dec_ops;
          instr_pc_d       = pc;
        end else begin
          instr_valid_d = 1'b0;
          halted_d      = 1'b1;
          error_d       = dec_err;
        end
      end
      S_ISSUE: begin
        if (instr_valid && instr_ready) begin
          instr_valid_d = 1'b0;
          pc_d          = pc + PC_W'(instr_len);
        end
      end
      S_WAIT_JMP: begin
        if (jmp_valid) pc_d = jmp_addr;
      end
      S_HALT: begin
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and program counter
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr_op       <= '0;
      instr_size     <= '0;
      instr_len      <= '0;
      instr_operands <= '0;
      instr_pc       <= '0;
      halted         <= 1'b0;
      error          <= ERR_NONE;
    end else begin
      pc             <= pc_d;
      instr_valid    <= instr_valid_d;
      instr_op       <= instr_op_d;
      instr_size     <= instr_size_d;
      instr_len      <= instr_len_d;
      instr_operands <= instr_operands_d;
      instr_pc       <= instr_pc_d;
      halted         <= halted_d;
      error          <= error_d;
    end
  end

endmodule
